// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
// Holds the data width, the NOP encoding loaded into IF/ID on reset,
// the queue slot record and a small PC helper.
package fetch_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One queue entry: request PC captured on grant, word captured on response.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } slot_t;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_slot_queue.sv
// fetch_slot_queue: ring buffer of in-flight fetch slots.
// Three pointers walk the ring in the same direction:
//   alloc_ptr - next slot handed out on a memory grant
//   fill_ptr  - oldest allocated slot still waiting for its response
//   head_ptr  - oldest slot, next to leave for IF/ID
// alloc_cnt counts every occupied slot (waiting or filled); fill_cnt counts
// filled slots not yet popped. Responses arrive in grant order, so fills
// always land on fill_ptr.
module fetch_slot_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         alloc,
  input  logic [XLEN-1:0]              alloc_pc,
  input  logic                         fill,
  input  logic [XLEN-1:0]              fill_data,
  input  logic                         pop,
  output slot_t                        head_slot,
  output logic [$clog2(DEPTH):0]       alloc_cnt,
  output logic [$clog2(DEPTH):0]       unfilled_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  slot_t          slots [DEPTH];
  logic [PW-1:0]  alloc_ptr;
  logic [PW-1:0]  fill_ptr;
  logic [PW-1:0]  head_ptr;
  logic [CW-1:0]  fill_cnt;

  assign head_slot    = slots[head_ptr];
  assign unfilled_cnt = alloc_cnt - fill_cnt;

  // Slot storage and pointers; a pop issued together with a fill of the same
  // slot (bypass) must leave it empty, so the pop update is written last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slots[i] <= '0;
      end
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      alloc_cnt <= '0;
      fill_cnt  <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slots[i].filled <= 1'b0;
      end
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      alloc_cnt <= '0;
      fill_cnt  <= '0;
    end else begin
      if (alloc) begin
        slots[alloc_ptr].pc     <= alloc_pc;
        slots[alloc_ptr].filled <= 1'b0;
        alloc_ptr               <= alloc_ptr + PW'(1);
      end
      if (fill) begin
        slots[fill_ptr].instr  <= fill_data;
        slots[fill_ptr].filled <= 1'b1;
        fill_ptr               <= fill_ptr + PW'(1);
      end
      if (pop) begin
        slots[head_ptr].filled <= 1'b0;
        head_ptr               <= head_ptr + PW'(1);
      end
      alloc_cnt <= alloc_cnt + CW'(alloc) - CW'(pop);
      fill_cnt  <= fill_cnt + CW'(fill) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: RV32 instruction fetch stage.
// Owns the fetch PC, issues in-order requests over a req/gnt/rvalid
// handshake, buffers returned words in fetch_slot_queue and drives the IF/ID
// register. Redirects from execute free every slot and remember how many
// responses are still in flight so they can be dropped on arrival.
// Build option FETCH_BYPASS_EN: a response landing on the head slot while
// IF/ID loads goes straight to instr_d (one cycle less latency). Without it
// instr_d is always fed from a queue flop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_e,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  output logic            valid_d,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d
);

  localparam int unsigned    CW       = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    FULL_LVL = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   discard_cnt;
  logic [CW-1:0]   alloc_cnt;
  logic [CW-1:0]   unfilled_cnt;
  logic [CW:0]     inflight;
  logic [CW:0]     discard_sum;
  slot_t           head_slot;
  logic            grant;
  logic            drop;
  logic            fill;
  logic            load;
  logic            bypass_hit;
  logic            pop;

  // Occupied slots plus responses owed to flushed requests bound new requests.
  assign inflight  = {1'b0, alloc_cnt} + {1'b0, discard_cnt};
  assign imem_req  = reset_n && !redirect_e && (inflight < FULL_LVL);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;

  // Responses owed to flushed requests come back first (in-order memory).
  assign drop = imem_rvalid && (discard_cnt != '0);
  assign fill = imem_rvalid && (discard_cnt == '0) && !redirect_e;
  assign load = !stall_d || !valid_d;

`ifdef FETCH_BYPASS_EN
  // Head slot is the one being filled when nothing is filled yet but something is allocated.
  assign bypass_hit = load && !head_slot.filled && fill &&
                      (alloc_cnt == unfilled_cnt) && (alloc_cnt != '0);
`else
  assign bypass_hit = 1'b0;
`endif

  assign pop = !redirect_e && load && (head_slot.filled || bypass_hit);

  // On redirect every unfilled slot becomes a response to throw away; one that
  // arrives this very cycle is already accounted for.
  assign discard_sum = ((discard_cnt != '0) || (unfilled_cnt != '0))
                     ? ({1'b0, discard_cnt} + {1'b0, unfilled_cnt} - (CW+1)'(imem_rvalid))
                     : '0;

  fetch_slot_queue #(.DEPTH(DEPTH)) u_slots (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (redirect_e),
    .alloc        (grant),
    .alloc_pc     (fetch_pc),
    .fill         (fill),
    .fill_data    (imem_rdata),
    .pop          (pop),
    .head_slot    (head_slot),
    .alloc_cnt    (alloc_cnt),
    .unfilled_cnt (unfilled_cnt)
  );

  // Fetch PC: jump on redirect, step by one word on each accepted request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_e) begin
      fetch_pc <= redirect_pc;
    end else if (grant) begin
      fetch_pc <= pc_inc(fetch_pc);
    end
  end

  // Count of wrong-path responses still to be swallowed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      discard_cnt <= '0;
    end else if (redirect_e) begin
      discard_cnt <= discard_sum[CW-1:0];
    end else if (drop) begin
      discard_cnt <= discard_cnt - CW'(1);
    end
  end

  // IF/ID register: flushed by redirect, loaded from the head slot (or the
  // bypassed response) whenever decode can take a new instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_d   <= 1'b0;
      instr_d   <= NOP_INSTR;
      pc_d      <= '0;
      pcplus4_d <= '0;
    end else if (redirect_e) begin
      valid_d <= 1'b0;
    end else if (load) begin
      if (head_slot.filled) begin
        valid_d   <= 1'b1;
        instr_d   <= head_slot.instr;
        pc_d      <= head_slot.pc;
        pcplus4_d <= pc_inc(head_slot.pc);
      end else if (bypass_hit) begin
        valid_d   <= 1'b1;
        instr_d   <= imem_rdata;
        pc_d      <= head_slot.pc;
        pcplus4_d <= pc_inc(head_slot.pc);
      end else begin
        valid_d <= 1'b0;
      end
    end
  end

endmodule
